// File: rtl/rs_station_param.sv
// Parametrised reservation station: holds instructions until both operands are ready, then dispatches them oldest-first.
// Latency: an issued ready instruction reaches out_valid one cycle after acceptance; a woken operand adds one cycle.
// Backpressure: in_ready=!full; out_* hold while out_valid && !out_ready; rdy=0 freezes everything.
module rs_station_param #(
    parameter int DEPTH   = 16,
    parameter int ROB_W   = 4,
    parameter int XLEN    = 32,
    parameter int OPC_W   = 6,
    parameter int NUM_CDB = 3,
    parameter int CNT_W   = $clog2(DEPTH+1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rdy,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPC_W-1:0]         in_opcode,
    input  logic [ROB_W-1:0]         in_rob_id,
    input  logic [XLEN-1:0]          in_v1,
    input  logic [XLEN-1:0]          in_v2,
    input  logic [ROB_W-1:0]         in_q1,
    input  logic [ROB_W-1:0]         in_q2,
    input  logic                     in_r1,
    input  logic                     in_r2,
    input  logic [XLEN-1:0]          in_imm,
    input  logic [XLEN-1:0]          in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPC_W-1:0]         out_opcode,
    output logic [ROB_W-1:0]         out_rob_id,
    output logic [XLEN-1:0]          out_val1,
    output logic [XLEN-1:0]          out_val2,
    output logic [XLEN-1:0]          out_imm,
    output logic [XLEN-1:0]          out_pc,
    input  logic [NUM_CDB-1:0]       cdb_valid,
    input  logic [NUM_CDB*ROB_W-1:0] cdb_rob_id,
    input  logic [NUM_CDB*XLEN-1:0]  cdb_data,
    output logic [CNT_W-1:0]         count
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic             vld;
        logic [OPC_W-1:0] opc;
        logic [ROB_W-1:0] rob;
        logic [XLEN-1:0]  v1;
        logic [XLEN-1:0]  v2;
        logic [ROB_W-1:0] q1;
        logic [ROB_W-1:0] q2;
        logic             r1;
        logic             r2;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  pc;
    } ent_t;

    typedef struct packed {
        logic [OPC_W-1:0] opc;
        logic [ROB_W-1:0] rob;
        logic [XLEN-1:0]  val1;
        logic [XLEN-1:0]  val2;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  pc;
    } out_t;

    ent_t             ent_q [DEPTH];
    ent_t             ent_d [DEPTH];
    // age_q[i][j]=1 means entry i was accepted before entry j
    logic [DEPTH-1:0] age_q [DEPTH];
    logic [DEPTH-1:0] age_d [DEPTH];
    out_t             out_q, out_d;
    logic             out_vld_q, out_vld_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [DEPTH-1:0] elig, win;
    logic             free_found, sel_found, issue, load;
    logic [IDX_W-1:0] free_idx, sel_idx;
    logic [XLEN:0]    m1, m2;

    // {hit, data} of the lowest-index channel broadcasting tag
    function automatic logic [XLEN:0] cdb_match(input logic [ROB_W-1:0] tag);
        logic [XLEN:0] r;
        r = '0;
        for (int c = NUM_CDB-1; c >= 0; c--) begin
            if (cdb_valid[c] && cdb_rob_id[c*ROB_W +: ROB_W] == tag)
                r = {1'b1, cdb_data[c*XLEN +: XLEN]};
        end
        return r;
    endfunction

    assign in_ready = (count_q != CNT_W'(DEPTH));
    assign issue    = in_valid && in_ready;

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!ent_q[i].vld && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end

        for (int i = 0; i < DEPTH; i++)
            elig[i] = ent_q[i].vld && ent_q[i].r1 && ent_q[i].r2;

        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            win[i] = elig[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && elig[j] && age_q[j][i])
                    win[i] = 1'b0;
            end
            if (win[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    assign load = sel_found && (!out_vld_q || out_ready);

    always_comb begin
        m1 = '0;
        m2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            age_d[i] = age_q[i];
            m1 = cdb_match(ent_q[i].q1);
            m2 = cdb_match(ent_q[i].q2);
            if (ent_q[i].vld && !ent_q[i].r1 && m1[XLEN]) begin
                ent_d[i].r1 = 1'b1;
                ent_d[i].v1 = m1[XLEN-1:0];
            end
            if (ent_q[i].vld && !ent_q[i].r2 && m2[XLEN]) begin
                ent_d[i].r2 = 1'b1;
                ent_d[i].v2 = m2[XLEN-1:0];
            end
        end

        if (load)
            ent_d[sel_idx].vld = 1'b0;

        if (issue) begin
            m1 = cdb_match(in_q1);
            m2 = cdb_match(in_q2);
            ent_d[free_idx].vld = 1'b1;
            ent_d[free_idx].opc = in_opcode;
            ent_d[free_idx].rob = in_rob_id;
            ent_d[free_idx].q1  = in_q1;
            ent_d[free_idx].q2  = in_q2;
            ent_d[free_idx].imm = in_imm;
            ent_d[free_idx].pc  = in_pc;
            ent_d[free_idx].r1  = in_r1 || m1[XLEN];
            ent_d[free_idx].v1  = (!in_r1 && m1[XLEN]) ? m1[XLEN-1:0] : in_v1;
            ent_d[free_idx].r2  = in_r2 || m2[XLEN];
            ent_d[free_idx].v2  = (!in_r2 && m2[XLEN]) ? m2[XLEN-1:0] : in_v2;
            for (int i = 0; i < DEPTH; i++)
                age_d[i][free_idx] = 1'b1;
            age_d[free_idx] = '0;
        end

        out_d     = out_q;
        out_vld_d = out_vld_q;
        if (load) begin
            out_vld_d = 1'b1;
            out_d     = '{opc: ent_q[sel_idx].opc, rob: ent_q[sel_idx].rob,
                          val1: ent_q[sel_idx].v1, val2: ent_q[sel_idx].v2,
                          imm: ent_q[sel_idx].imm, pc: ent_q[sel_idx].pc};
        end else if (out_ready) begin
            out_vld_d = 1'b0;
        end

        count_d = count_q + CNT_W'(issue) - CNT_W'(load);

        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i] = '0;
                age_d[i] = '0;
            end
            out_d     = '0;
            out_vld_d = 1'b0;
            count_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
                age_q[i] <= '0;
            end
            out_q     <= '0;
            out_vld_q <= 1'b0;
            count_q   <= '0;
        end else if (rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
                age_q[i] <= age_d[i];
            end
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
            count_q   <= count_d;
        end
    end

    assign out_valid  = out_vld_q;
    assign out_opcode = out_q.opc;
    assign out_rob_id = out_q.rob;
    assign out_val1   = out_q.val1;
    assign out_val2   = out_q.val2;
    assign out_imm    = out_q.imm;
    assign out_pc     = out_q.pc;
    assign count      = count_q;
endmodule

// File: tb/tb_rs_station_param.sv
// Directed bench for rs_station_param: issue/wakeup/select ordering, bypass, tag 0, full, clear and rdy freeze.
module tb_rs_station_param;
    localparam int DEPTH = 16, ROB_W = 4, XLEN = 32, OPC_W = 6, NUM_CDB = 3;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic                     clk = 1'b0;
    logic                     rst_n, rdy, clear;
    logic                     in_valid, in_ready;
    logic [OPC_W-1:0]         in_opcode;
    logic [ROB_W-1:0]         in_rob_id, in_q1, in_q2;
    logic [XLEN-1:0]          in_v1, in_v2, in_imm, in_pc;
    logic                     in_r1, in_r2;
    logic                     out_valid, out_ready;
    logic [OPC_W-1:0]         out_opcode;
    logic [ROB_W-1:0]         out_rob_id;
    logic [XLEN-1:0]          out_val1, out_val2, out_imm, out_pc;
    logic [NUM_CDB-1:0]       cdb_valid;
    logic [NUM_CDB*ROB_W-1:0] cdb_rob_id;
    logic [NUM_CDB*XLEN-1:0]  cdb_data;
    logic [CNT_W-1:0]         count;

    int pass_cnt = 0;
    int total_cnt = 0;

    rs_station_param #(.DEPTH(DEPTH), .ROB_W(ROB_W), .XLEN(XLEN), .OPC_W(OPC_W), .NUM_CDB(NUM_CDB)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_rob_id(in_rob_id),
        .in_v1(in_v1), .in_v2(in_v2), .in_q1(in_q1), .in_q2(in_q2), .in_r1(in_r1), .in_r2(in_r2),
        .in_imm(in_imm), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode), .out_rob_id(out_rob_id),
        .out_val1(out_val1), .out_val2(out_val2), .out_imm(out_imm), .out_pc(out_pc),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_data(cdb_data), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp)
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        else
            pass_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cdb(input int ch, input logic [ROB_W-1:0] tag, input logic [XLEN-1:0] dat);
        cdb_valid[ch]                 = 1'b1;
        cdb_rob_id[ch*ROB_W +: ROB_W] = tag;
        cdb_data[ch*XLEN +: XLEN]     = dat;
    endtask

    task automatic clr_cdb();
        cdb_valid  = '0;
        cdb_rob_id = '0;
        cdb_data   = '0;
    endtask

    task automatic issue(input logic [ROB_W-1:0] rob, input logic [XLEN-1:0] v1, input logic [ROB_W-1:0] q1,
                         input logic r1, input logic [XLEN-1:0] v2, input logic [ROB_W-1:0] q2, input logic r2);
        in_valid  = 1'b1;
        in_opcode = OPC_W'(rob) + 6'd1;
        in_rob_id = rob;
        in_v1 = v1; in_q1 = q1; in_r1 = r1;
        in_v2 = v2; in_q2 = q2; in_r2 = r2;
        in_imm = 32'h1000 + XLEN'(rob);
        in_pc  = 32'h4000 + (XLEN'(rob) << 2);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rdy = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_opcode = '0; in_rob_id = '0; in_v1 = '0; in_v2 = '0; in_q1 = '0; in_q2 = '0;
        in_r1 = 1'b0; in_r2 = 1'b0; in_imm = '0; in_pc = '0;
        clr_cdb();
        #12 rst_n = 1'b1;
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_rob", 64'(out_rob_id), 64'd0);

        // ready issue: not visible at the acceptance edge, visible one cycle later
        issue(4'd3, 32'hA, 4'd0, 1'b1, 32'hB, 4'd0, 1'b1);
        chk("lat_out_valid_early", 64'(out_valid), 64'd0);
        chk("lat_count_1", 64'(count), 64'd1);
        tick();
        chk("lat_out_valid", 64'(out_valid), 64'd1);
        chk("lat_out_rob", 64'(out_rob_id), 64'd3);
        chk("lat_out_opc", 64'(out_opcode), 64'd4);
        chk("lat_out_imm", 64'(out_imm), 64'h1003);
        chk("lat_out_pc", 64'(out_pc), 64'h400c);
        chk("lat_count_0", 64'(count), 64'd0);

        for (int i = 0; i < 5; i++)
            issue(ROB_W'(8 + i), 32'h0, 4'd1, 1'b0, 32'h0, 4'd1, 1'b1);
        chk("held_count", 64'(count), 64'd5);

        rst_n = 1'b0;
        #2;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        tick();
        issue(4'd3, 32'h1, 4'd0, 1'b1, 32'h2, 4'd0, 1'b1);
        chk("post_rst_early", 64'(out_valid), 64'd0);
        tick();
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_rob", 64'(out_rob_id), 64'd3);
        out_ready = 1'b1;
        tick();
        chk("drain_valid", 64'(out_valid), 64'd0);

        // oldest-first across staggered wakeups: C, B, A
        issue(4'd2, 32'h0, 4'd7, 1'b0, 32'h22, 4'd0, 1'b1);
        issue(4'd5, 32'h55, 4'd0, 1'b1, 32'h0, 4'd9, 1'b0);
        issue(4'd6, 32'h66, 4'd0, 1'b1, 32'h67, 4'd0, 1'b1);
        set_cdb(0, 4'd9, 32'h9999);
        tick();
        chk("order_C", 64'(out_rob_id), 64'd6);
        clr_cdb();
        set_cdb(0, 4'd7, 32'h7777);
        tick();
        chk("order_B", 64'(out_rob_id), 64'd5);
        chk("order_B_val2", 64'(out_val2), 64'h9999);
        clr_cdb();
        tick();
        chk("order_A", 64'(out_rob_id), 64'd2);
        chk("order_A_val1", 64'(out_val1), 64'h7777);
        tick();
        chk("order_empty", 64'(out_valid), 64'd0);

        // simultaneous wakeup resolves by age (B issued first)
        issue(4'd5, 32'h55, 4'd0, 1'b1, 32'h0, 4'd9, 1'b0);
        issue(4'd2, 32'h0, 4'd7, 1'b0, 32'h22, 4'd0, 1'b1);
        set_cdb(0, 4'd7, 32'h70);
        set_cdb(1, 4'd9, 32'h90);
        tick();
        clr_cdb();
        tick();
        chk("same_wake_first", 64'(out_rob_id), 64'd5);
        tick();
        chk("same_wake_second", 64'(out_rob_id), 64'd2);
        chk("same_wake_val1", 64'(out_val1), 64'h70);
        tick();

        // issue bypass from channel 2
        set_cdb(2, 4'd4, 32'hDEAD_BEEF);
        issue(4'd8, 32'h0, 4'd4, 1'b0, 32'h5, 4'd0, 1'b1);
        clr_cdb();
        tick();
        chk("bypass_valid", 64'(out_valid), 64'd1);
        chk("bypass_val1", 64'(out_val1), 64'hDEAD_BEEF);
        tick();

        // tag 0 with two matching channels; ready operand with q=0 untouched
        issue(4'd9, 32'h55, 4'd0, 1'b1, 32'h0, 4'd0, 1'b0);
        set_cdb(0, 4'd0, 32'h11);
        set_cdb(1, 4'd0, 32'h22);
        tick();
        clr_cdb();
        tick();
        chk("tag0_rob", 64'(out_rob_id), 64'd9);
        chk("tag0_val2", 64'(out_val2), 64'h11);
        chk("tag0_val1_kept", 64'(out_val1), 64'h55);
        tick();

        // backpressure and full: DEPTH+1 fit, the next one is dropped
        out_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++)
            issue(ROB_W'(i), 32'h100 + 32'(i), 4'd0, 1'b1, 32'h0, 4'd0, 1'b1);
        chk("full_count", 64'(count), 64'(DEPTH));
        chk("full_in_ready", 64'(in_ready), 64'd0);
        issue(4'hF, 32'h1FF, 4'd0, 1'b1, 32'h0, 4'd0, 1'b1);
        chk("drop_count", 64'(count), 64'(DEPTH));
        tick(); tick();
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_val1", 64'(out_val1), 64'h100);
        out_ready = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            tick();
            chk($sformatf("drain_%0d", i), 64'(out_val1), 64'h100 + 64'(i));
        end
        tick();
        chk("drain_done_valid", 64'(out_valid), 64'd0);
        chk("drain_done_count", 64'(count), 64'd0);

        // clear with 8 held entries and a stalled output
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++)
            issue(ROB_W'(i + 1), 32'h0, 4'd0, 1'b1, 32'h0, 4'd0, 1'b1);
        chk("pre_clear_count", 64'(count), 64'd8);
        chk("pre_clear_valid", 64'(out_valid), 64'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_count", 64'(count), 64'd0);
        chk("clear_valid", 64'(out_valid), 64'd0);
        chk("clear_rob", 64'(out_rob_id), 64'd0);
        out_ready = 1'b1;

        // rdy=0 freezes: broadcast and issue ignored
        issue(4'd10, 32'h0, 4'd3, 1'b0, 32'h0, 4'd0, 1'b1);
        rdy = 1'b0;
        set_cdb(0, 4'd3, 32'h77);
        issue(4'd11, 32'h0, 4'd0, 1'b1, 32'h0, 4'd0, 1'b1);
        clr_cdb();
        chk("frz_count", 64'(count), 64'd1);
        rdy = 1'b1;
        tick(); tick();
        chk("frz_no_capture", 64'(out_valid), 64'd0);
        set_cdb(0, 4'd3, 32'h88);
        tick();
        clr_cdb();
        tick();
        chk("frz_after_valid", 64'(out_valid), 64'd1);
        chk("frz_after_val1", 64'(out_val1), 64'h88);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
